// File: rtl/noc_pkg.sv
// Shared mesh-router constants: port indices, flit-type encodings, arbiter state.
package noc_pkg;

    localparam int NUM_PORTS   = 5;
    localparam int PORT_W      = 3;
    localparam int FLIT_TYPE_W = 2;

    // Flit-type encodings. Bit 0 marks a packet start and bit 1 marks a packet end.
    localparam logic [FLIT_TYPE_W-1:0] FT_BODY     = 2'b00;
    localparam logic [FLIT_TYPE_W-1:0] FT_HEAD     = 2'b01;
    localparam logic [FLIT_TYPE_W-1:0] FT_TAIL     = 2'b10;
    localparam logic [FLIT_TYPE_W-1:0] FT_HEADTAIL = 2'b11;

    localparam logic [PORT_W-1:0] P_NORTH = 3'd0;
    localparam logic [PORT_W-1:0] P_EAST  = 3'd1;
    localparam logic [PORT_W-1:0] P_SOUTH = 3'd2;
    localparam logic [PORT_W-1:0] P_WEST  = 3'd3;
    localparam logic [PORT_W-1:0] P_LOCAL = 3'd4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping mod N.
module rr_arbiter #(
    parameter int N = 5,
    parameter int W = 3
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] idx_o,
    output logic         vld_o
);

    logic [W:0] cand;

    // Scan offsets from farthest to nearest so the nearest requester is assigned last and wins.
    always_comb begin
        idx_o = '0;
        cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_i} + (W+1)'(k);
            if (cand >= (W+1)'(N)) cand = cand - (W+1)'(N);
            if (req_i[cand[W-1:0]]) idx_o = cand[W-1:0];
        end
        vld_o = |req_i;
        gnt_o = vld_o ? (N'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/wormhole_output_arbiter.sv
// Per-output wormhole arbiter: round-robin among head flits, then locks the
// winner until its tail transfers. Transfers are gated by downstream ON_OFF.
module wormhole_output_arbiter
    import noc_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             req,
    input  logic [NUM_PORTS*FLIT_TYPE_W-1:0] in_flit_type,
    input  logic                             ON_OFF_signal,
    output logic [NUM_PORTS-1:0]             grant,
    output logic [PORT_W-1:0]                sel,
    output logic                             locked,
    output logic [NUM_PORTS-1:0]             rd_en,
    output logic                             wr_en
);

    arb_state_e             state_q;
    logic [PORT_W-1:0]      owner_q, ptr_q, sel_q;
    logic [NUM_PORTS-1:0]   grant_q;
    logic                   locked_q;

    logic [NUM_PORTS-1:0]   head_vec, eligible, win_gnt;
    logic [PORT_W-1:0]      win_idx;
    logic                   win_vld;
    logic [FLIT_TYPE_W-1:0] own_type;
    logic                   xfer;

    // Decode head flags for every input and pick out the owner's front-flit type.
    always_comb begin
        head_vec = '0;
        own_type = FT_BODY;
        for (int i = 0; i < NUM_PORTS; i++) begin
            head_vec[i] = in_flit_type[i*FLIT_TYPE_W];
            if (owner_q == PORT_W'(i)) own_type = in_flit_type[i*FLIT_TYPE_W +: FLIT_TYPE_W];
        end
    end

    // Only head flits compete; body/tail flits of other packets must never steal the output.
    assign eligible = req & head_vec;

    rr_arbiter #(.N(NUM_PORTS), .W(PORT_W)) u_rr (
        .req_i (eligible),
        .ptr_i (ptr_q),
        .gnt_o (win_gnt),
        .idx_o (win_idx),
        .vld_o (win_vld)
    );

    // grant_q is already one-hot on the owner, so it doubles as the owner's request mask.
    assign xfer   = locked_q & (|(req & grant_q)) & ON_OFF_signal;
    assign rd_en  = xfer ? grant_q : '0;
    assign wr_en  = xfer;
    assign grant  = grant_q;
    assign sel    = sel_q;
    assign locked = locked_q;

    // IDLE/LOCKED FSM with registered grant/sel/locked; pointer advances only on a new lock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            ptr_q    <= '0;
            sel_q    <= '0;
            grant_q  <= '0;
            locked_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (win_vld) begin
                        state_q  <= ST_LOCKED;
                        owner_q  <= win_idx;
                        ptr_q    <= (win_idx == PORT_W'(NUM_PORTS - 1)) ? '0 : win_idx + 1'b1;
                        sel_q    <= win_idx;
                        grant_q  <= win_gnt;
                        locked_q <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (xfer && own_type[1]) begin
                        state_q  <= ST_IDLE;
                        sel_q    <= '0;
                        grant_q  <= '0;
                        locked_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wormhole_output_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized packet-stream phase, all checked each cycle against a behavioural model.
module tb_wormhole_output_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] req;
    logic [9:0] in_flit_type;
    logic       ON_OFF_signal;
    logic [4:0] grant;
    logic [2:0] sel;
    logic       locked;
    logic [4:0] rd_en;
    logic       wr_en;

    int n_chk  = 0;
    int n_pass = 0;

    wormhole_output_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .in_flit_type  (in_flit_type),
        .ON_OFF_signal (ON_OFF_signal),
        .grant         (grant),
        .sel           (sel),
        .locked        (locked),
        .rd_en         (rd_en),
        .wr_en         (wr_en)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic m_locked;
    int   m_owner, m_ptr;
    int   pos [5];
    int   len [5];

    function automatic logic [1:0] ftype(int i);
        return in_flit_type[i*2 +: 2];
    endfunction

    function automatic bit is_head(logic [1:0] t);
        return (t == 2'b01) || (t == 2'b11);
    endfunction

    function automatic bit is_tail(logic [1:0] t);
        return (t == 2'b10) || (t == 2'b11);
    endfunction

    // Round-robin winner among requesting heads, or -1 if nobody is eligible.
    function automatic int winner();
        for (int k = 0; k < 5; k++) begin
            int c = (m_ptr + k) % 5;
            if (req[c] && is_head(ftype(c))) return c;
        end
        return -1;
    endfunction

    function automatic bit m_xfer();
        return m_locked && req[m_owner] && ON_OFF_signal;
    endfunction

    function automatic logic [4:0] m_grant();
        return m_locked ? 5'(1 << m_owner) : 5'd0;
    endfunction

    function automatic logic [1:0] src_type(int i);
        if (len[i] == 1)          return 2'b11;
        if (pos[i] == 0)          return 2'b01;
        if (pos[i] == len[i] - 1) return 2'b10;
        return 2'b00;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_locked <= 1'b0;
            m_owner  <= 0;
            m_ptr    <= 0;
            for (int i = 0; i < 5; i++) begin
                pos[i] <= 0;
                len[i] <= 1 + (i % 4);
            end
        end else if (m_locked) begin
            if (m_xfer()) begin
                if (pos[m_owner] + 1 >= len[m_owner]) begin
                    pos[m_owner] <= 0;
                    len[m_owner] <= int'($urandom_range(1, 4));
                end else begin
                    pos[m_owner] <= pos[m_owner] + 1;
                end
                if (is_tail(ftype(m_owner))) m_locked <= 1'b0;
            end
        end else if (winner() >= 0) begin
            m_locked <= 1'b1;
            m_owner  <= winner();
            m_ptr    <= (winner() + 1) % 5;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic cmp_model();
        chk("grant",  32'(grant),  32'(m_grant()));
        chk("sel",    32'(sel),    m_locked ? 32'(m_owner) : 32'd0);
        chk("locked", 32'(locked), 32'(m_locked));
        chk("rd_en",  32'(rd_en),  m_xfer() ? 32'(1 << m_owner) : 32'd0);
        chk("wr_en",  32'(wr_en),  32'(m_xfer()));
    endtask

    task automatic step(logic [4:0] r, logic [9:0] t, logic o);
        @(negedge clk);
        req = r; in_flit_type = t; ON_OFF_signal = o;
        #1;
        cmp_model();
    endtask

    function automatic logic [9:0] all_t(logic [1:0] t);
        return {5{t}};
    endfunction

    function automatic logic [9:0] set_t(logic [9:0] base, int p, logic [1:0] t);
        logic [9:0] v = base;
        v[p*2 +: 2] = t;
        return v;
    endfunction

    initial begin
        rst = 1'b1; req = '0; in_flit_type = '0; ON_OFF_signal = 1'b0;
        #1;
        chk("rst_grant",  32'(grant),  32'd0);
        chk("rst_sel",    32'(sel),    32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_wr",     32'(wr_en),  32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;

        // Round-robin over single-flit packets from inputs 0, 2, 4.
        step(5'b10101, all_t(2'b11), 1'b1); chk("rr_c0_grant", 32'(grant), 32'd0);
        step(5'b10101, all_t(2'b11), 1'b1); chk("rr_c1_grant", 32'(grant), 32'b00001);
                                            chk("rr_c1_wr",    32'(wr_en), 32'd1);
        step(5'b10101, all_t(2'b11), 1'b1); chk("rr_c2_idle",  32'(grant), 32'd0);
        step(5'b10101, all_t(2'b11), 1'b1); chk("rr_c3_grant", 32'(grant), 32'b00100);
        step(5'b10101, all_t(2'b11), 1'b1);
        step(5'b10101, all_t(2'b11), 1'b1); chk("rr_c5_grant", 32'(grant), 32'b10000);
        step(5'b10101, all_t(2'b11), 1'b1);
        step(5'b10101, all_t(2'b11), 1'b1); chk("rr_c7_grant", 32'(grant), 32'b00001);
        step(5'b00000, all_t(2'b00), 1'b1);

        // Single east packet: head waits one IDLE cycle, then four transfers.
        step(5'b00010, all_t(2'b01), 1'b1); chk("sp_c0_wr",     32'(wr_en),  32'd0);
        step(5'b00010, all_t(2'b01), 1'b1); chk("sp_c1_grant",  32'(grant),  32'b00010);
                                            chk("sp_c1_sel",    32'(sel),    32'd1);
                                            chk("sp_c1_rd",     32'(rd_en),  32'b00010);
        step(5'b00010, all_t(2'b00), 1'b1);
        step(5'b00010, all_t(2'b00), 1'b1);
        step(5'b00010, all_t(2'b10), 1'b1); chk("sp_c4_wr",     32'(wr_en),  32'd1);
        step(5'b00000, all_t(2'b00), 1'b1); chk("sp_c5_locked", 32'(locked), 32'd0);

        // Back-pressure during an east-owned packet.
        step(5'b00010, all_t(2'b01), 1'b1);
        step(5'b00010, all_t(2'b01), 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(5'b00010, all_t(2'b00), 1'b0);
            chk("bp_rd",    32'(rd_en), 32'd0);
            chk("bp_grant", 32'(grant), 32'b00010);
        end
        step(5'b00010, all_t(2'b00), 1'b1); chk("bp_resume_wr", 32'(wr_en), 32'd1);
        step(5'b00010, all_t(2'b10), 1'b1);
        step(5'b00000, all_t(2'b00), 1'b1);

        // Eligibility: a body flit at the front of west never wins.
        step(5'b01000, all_t(2'b00), 1'b1);
        step(5'b01000, all_t(2'b00), 1'b1); chk("el_body_nogrant", 32'(grant), 32'd0);
        step(5'b01000, all_t(2'b01), 1'b1);
        step(5'b01000, all_t(2'b01), 1'b1); chk("el_head_grant",   32'(grant), 32'b01000);
        step(5'b01000, all_t(2'b10), 1'b1);
        step(5'b00000, all_t(2'b00), 1'b1);

        // Starvation: south owns, its buffer empties while north waits with a head.
        step(5'b00100, all_t(2'b01), 1'b1);
        step(5'b00100, all_t(2'b01), 1'b1);
        for (int i = 0; i < 2; i++) begin
            step(5'b00001, set_t(all_t(2'b01), 2, 2'b00), 1'b1);
            chk("st_hold_grant", 32'(grant), 32'b00100);
            chk("st_hold_wr",    32'(wr_en), 32'd0);
        end
        step(5'b00101, set_t(all_t(2'b01), 2, 2'b00), 1'b1); chk("st_body_rd", 32'(rd_en), 32'b00100);
        step(5'b00101, set_t(all_t(2'b01), 2, 2'b10), 1'b1); chk("st_tail_grant", 32'(grant), 32'b00100);
        step(5'b00001, all_t(2'b11), 1'b1); chk("st_idle", 32'(grant), 32'd0);
        step(5'b00001, all_t(2'b11), 1'b1); chk("st_north_grant", 32'(grant), 32'b00001);

        // Mid-packet asynchronous reset, then arbitration must restart from north.
        step(5'b11111, all_t(2'b01), 1'b1);
        step(5'b11111, all_t(2'b00), 1'b1); chk("pre_rst_grant", 32'(grant), 32'b00010);
        @(negedge clk); rst = 1'b1; #1;
        chk("arst_grant",  32'(grant),  32'd0);
        chk("arst_sel",    32'(sel),    32'd0);
        chk("arst_locked", 32'(locked), 32'd0);
        chk("arst_rd",     32'(rd_en),  32'd0);
        chk("arst_wr",     32'(wr_en),  32'd0);
        @(negedge clk); rst = 1'b0;
        step(5'b11111, all_t(2'b01), 1'b1);
        step(5'b11111, all_t(2'b01), 1'b1); chk("post_rst_grant", 32'(grant), 32'b00001);

        // Randomized packet streams with random requests and back-pressure.
        for (int c = 0; c < 3000; c++) begin
            logic [9:0] t;
            logic [4:0] r;
            for (int i = 0; i < 5; i++) begin
                t[i*2 +: 2] = src_type(i);
                r[i]        = ($urandom_range(0, 3) != 0);
            end
            step(r, t, ($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/wormhole_output_arbiter.md
Name: wormhole_output_arbiter

Overview:
- Per-output-port controller for the mesh router's switch allocator. One instance per output direction (north/east/south/west/local).
- Picks one of the five input buffers that request this output, round-robin among head flits.
- Holds the winner from head flit to tail flit (wormhole lock).
- Produces the crossbar select, the input-buffer read enable and the downstream write enable, gated by the downstream ON_OFF flow-control signal.

Parameters:
- NUM_PORTS, 5, number of input ports; index 0=north, 1=east, 2=south, 3=west, 4=local.
- PORT_W, 3, width of a binary port index.
- FLIT_TYPE_W, 2, width of the flit-type field carried with each request.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_PORTS  req[i]=1 when input buffer i is non-empty and its route decode selects this output.
- in_flit_type  input  NUM_PORTS*FLIT_TYPE_W  type of the front flit of buffer i, bits [2i+1:2i]; 01 head, 00 body, 10 tail, 11 head+tail.
- ON_OFF_signal  input  1  downstream flow control; 1 = downstream can accept a flit this cycle.
- grant  output  NUM_PORTS  one-hot owner of this output; all zero when unlocked.
- sel  output  PORT_W  binary index of the owner, drives the crossbar mux.
- locked  output  1  1 while a packet holds this output.
- rd_en  output  NUM_PORTS  pop strobe to the owner's input buffer.
- wr_en  output  1  write strobe to the downstream buffer.

Behaviour:
- Reset (asynchronous, takes effect immediately on rst=1):
  - state=IDLE, owner=0, rr pointer=0.
  - grant=0, sel=0, locked=0, rd_en=0, wr_en=0.
  - Any in-flight packet is abandoned; there is no recovery of partial packets.
- State IDLE:
  - eligible = req & is_head, where is_head means type 01 or 11. Body and tail flits never win arbitration.
  - If eligible is non-zero, pick the first set bit scanning ptr, ptr+1, … mod NUM_PORTS.
  - On the next edge: state=LOCKED, owner=winner, ptr=(winner+1) mod NUM_PORTS.
  - No transfer happens in an IDLE cycle, so allocation latency is 1 cycle.
  - If eligible is zero, remain in IDLE; ptr is unchanged.
- State LOCKED:
  - grant=onehot(owner), sel=owner, locked=1; all three are registered.
  - xfer = req[owner] & ON_OFF_signal, combinational from registered state and current inputs.
  - rd_en[owner]=xfer, other rd_en bits 0; wr_en=xfer.
  - If xfer and the owner's type is 10 or 11: next state=IDLE, and grant, sel and locked clear on the next edge.
  - Otherwise stay LOCKED.
- Boundary cases:
  - ON_OFF_signal=0: no transfer; lock, owner and ptr are held.
  - req[owner]=0 mid-packet (buffer empty): no transfer; lock held indefinitely.
  - Requests from non-owners while LOCKED: ignored; ptr is not advanced.
  - Head+tail (type 11): lock for exactly one transferring cycle, then IDLE.
  - A tail transfers in cycle N. A waiting head can be chosen in cycle N+1 (IDLE) and transfer in N+2. Per-output throughput is one packet per (flits+1) cycles minimum.
  - The owner presenting type 01 again mid-packet is treated as body; no re-arbitration.
- wr_en and rd_en are never asserted in IDLE. At most one rd_en bit is set in any cycle.

Decomposition:
- Shared package noc_pkg holds:
  - flit-type localparams FT_BODY=2'b00, FT_HEAD=2'b01, FT_TAIL=2'b10, FT_HEADTAIL=2'b11;
  - port index constants P_NORTH..P_LOCAL (0..4);
  - NUM_PORTS and PORT_W.
- Sub-module rr_arbiter: combinational round-robin picker. Inputs: request vector and pointer. Outputs: one-hot grant and binary index. Reused by the virtual-channel allocator later.
- The top level holds the IDLE/LOCKED FSM, owner and pointer registers, and output gating.

Test Plan:
- Reset: drive rst=1 mid-simulation with requests active -> grant=0, sel=0, locked=0, rd_en=0, wr_en=0 in the same cycle; the first arbitration after release starts from ptr=0.
- Single packet:
  - Stimulus: req=5'b00010 with types head, body, body, tail on consecutive cycles, ON_OFF_signal=1.
  - Cycle 1 -> grant=5'b00010, sel=1, locked=1.
  - Cycles 1-4 -> rd_en=5'b00010, wr_en=1.
  - Cycle 5 -> locked=0.
- Round-robin:
  - Stimulus: req=5'b10101, all heads, single-flit packets (type 11).
  - Required grant order 0, 2, 4, 0, with one IDLE cycle between each grant.
- Back-pressure:
  - Stimulus: ON_OFF_signal=0 for 3 cycles during the body of an east-owned packet.
  - Response: rd_en=0, wr_en=0, grant=5'b00010 held; transfers resume the cycle ON_OFF_signal returns to 1.
- Eligibility: in IDLE, req=5'b01000 with a body flit -> no grant. Once it changes to head -> grant=5'b01000 the next cycle.
- Mid-packet starvation:
  - Stimulus: owner req drops to 0 for 2 cycles while input 0 requests with a head.
  - Response: lock held on the owner and no grant to input 0 until the owner's tail transfers.
